// File: rtl/obi_rready_buffer.sv
// Adds rready back-pressure in front of an OBI subordinate that cannot stall its R channel.
// Optional same-cycle R bypass when OBI_RREADY_BUFFER_BYPASS_EN is defined.
//
// Port layout (packed, MSB first):
//   *_req : {a[AChanWidth-1:0], req, rready}
//   *_rsp : {gnt, rvalid, r[RChanWidth-1:0]}
module obi_rready_buffer #(
    parameter int unsigned AChanWidth = 32,
    parameter int unsigned RChanWidth = 32,
    parameter int unsigned Depth      = 2,
    parameter bit          UseRReady  = 1'b1,
    parameter bit          Integrity  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AChanWidth+1:0] sbr_req_i,
    output logic [RChanWidth+1:0] sbr_rsp_o,
    output logic [AChanWidth+1:0] mgr_req_o,
    input  logic [RChanWidth+1:0] mgr_rsp_i
);

    localparam int unsigned MemDepth = (Depth > 0) ? Depth : 1;
    localparam int unsigned CntW     = $clog2(MemDepth + 1);
    localparam int unsigned PtrW     = (MemDepth > 1) ? $clog2(MemDepth) : 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(MemDepth);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(MemDepth - 1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    if (Depth == 0) begin : g_bad_depth
        $fatal(1, "obi_rready_buffer: Depth must be at least 1");
    end
    if (!UseRReady) begin : g_bad_rready
        $fatal(1, "obi_rready_buffer: ObiCfg.UseRReady must be 1");
    end
    if (Integrity) begin : g_bad_integrity
        $fatal(1, "obi_rready_buffer: ObiCfg.Integrity must be 0");
    end

    // ---------------------------------------------------------------------
    // Port unpacking
    // ---------------------------------------------------------------------
    logic [AChanWidth-1:0] sbr_a;
    logic                  sbr_req;
    logic                  sbr_rready;
    logic                  mgr_gnt;
    logic                  mgr_rvalid;
    logic [RChanWidth-1:0] mgr_r;

    assign {sbr_a, sbr_req, sbr_rready} = sbr_req_i;
    assign {mgr_gnt, mgr_rvalid, mgr_r} = mgr_rsp_i;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       fill_q, fill_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [RChanWidth-1:0] mem_q [MemDepth];
    logic [RChanWidth-1:0] mem_d [MemDepth];

    logic                  full;
    logic                  empty;
    logic                  fifo_full;
    logic                  bypass;
    logic                  mgr_req;
    logic                  sbr_gnt;
    logic                  sbr_rvalid;
    logic [RChanWidth-1:0] sbr_r;
    logic                  a_hs;
    logic                  r_hs;
    logic                  push;
    logic                  pop;

    // Credit limit comes only from registered state, so rready never reaches gnt.
    assign full      = (cnt_q == DepthCnt);
    assign empty     = (fill_q == '0);
    assign fifo_full = (fill_q == DepthCnt);

    // ---------------------------------------------------------------------
    // A channel: zero-latency pass-through, gated by the credit limit
    // ---------------------------------------------------------------------
    assign mgr_req = sbr_req && !full;
    assign sbr_gnt = mgr_gnt && !full;
    assign a_hs    = mgr_req && mgr_gnt;

    assign mgr_req_o = {sbr_a, mgr_req, 1'b1};

    // ---------------------------------------------------------------------
    // R channel
    // ---------------------------------------------------------------------
`ifdef OBI_RREADY_BUFFER_BYPASS_EN
    assign bypass = empty && mgr_rvalid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        sbr_rvalid = 1'b0;
        sbr_r      = '0;
        if (!empty) begin
            sbr_rvalid = 1'b1;
            sbr_r      = mem_q[rd_ptr_q];
        end else if (bypass) begin
            sbr_rvalid = 1'b1;
            sbr_r      = mgr_r;
        end
    end

    assign r_hs = sbr_rvalid && sbr_rready;
    assign pop  = !empty && sbr_rready;
    // A bypassed response that is accepted immediately never touches the FIFO.
    assign push = mgr_rvalid && !(bypass && sbr_rready);

    assign sbr_rsp_o = {sbr_gnt, sbr_rvalid, sbr_r};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrOne;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (a_hs && !r_hs) begin
            cnt_d = cnt_q + CntOne;
        end else if (!a_hs && r_hs) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = mgr_r;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            fill_d = fill_q + CntOne;
        end else if (!push && pop) begin
            fill_d = fill_q - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MemDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // ---------------------------------------------------------------------
    // Protocol checks
    // ---------------------------------------------------------------------
`ifndef SYNTHESIS
    a_rvalid_has_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
        mgr_rvalid |-> (cnt_q != '0))
        else $error("obi_rready_buffer: mgr rvalid without outstanding transaction");

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && fifo_full) |-> pop)
        else $error("obi_rready_buffer: response FIFO overflow");

    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sbr_req && !sbr_gnt) |=> (sbr_req && $stable(sbr_a)))
        else $error("obi_rready_buffer: request changed while waiting for gnt");
`endif

endmodule

// File: tb/tb_obi_rready_buffer.sv
// Self-checking bench for obi_rready_buffer: directed vector table, hand sequences
// for latency and mid-operation reset, then random traffic against a queue model.
module tb_obi_rready_buffer;

    localparam int AW    = 8;
    localparam int RW    = 8;
    localparam int DEPTH = 2;

`ifdef OBI_RREADY_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i;
    logic          rst_ni;
    logic [AW-1:0] a;
    logic          req;
    logic          rready;
    logic          mgnt;
    logic          mrvalid;
    logic [RW-1:0] mr;

    logic [AW+1:0] sbr_req_i;
    logic [RW+1:0] sbr_rsp_o;
    logic [AW+1:0] mgr_req_o;
    logic [RW+1:0] mgr_rsp_i;

    assign sbr_req_i = {a, req, rready};
    assign mgr_rsp_i = {mgnt, mrvalid, mr};

    logic          o_gnt, o_rvalid, o_mreq, o_mrready;
    logic [RW-1:0] o_r;
    logic [AW-1:0] o_ma;
    assign o_gnt     = sbr_rsp_o[RW+1];
    assign o_rvalid  = sbr_rsp_o[RW];
    assign o_r       = sbr_rsp_o[RW-1:0];
    assign o_ma      = mgr_req_o[AW+1:2];
    assign o_mreq    = mgr_req_o[1];
    assign o_mrready = mgr_req_o[0];

    obi_rready_buffer #(
        .AChanWidth(AW),
        .RChanWidth(RW),
        .Depth     (DEPTH),
        .UseRReady (1'b1),
        .Integrity (1'b0)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sbr_req_i(sbr_req_i),
        .sbr_rsp_o(sbr_rsp_o),
        .mgr_req_o(mgr_req_o),
        .mgr_rsp_i(mgr_rsp_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic eg, input logic emreq,
                              input logic erv, input logic [RW-1:0] er);
        chk({tag, ".gnt"},     32'(o_gnt),     32'(eg));
        chk({tag, ".mgr_req"}, 32'(o_mreq),    32'(emreq));
        chk({tag, ".rvalid"},  32'(o_rvalid),  32'(erv));
        chk({tag, ".rdata"},   32'(o_r),       32'(er));
        chk({tag, ".mgr_a"},   32'(o_ma),      32'(a));
        chk({tag, ".rready1"}, 32'(o_mrready), 32'd1);
    endtask

    task automatic drive(input logic rq, input logic [AW-1:0] aa, input logic rr,
                         input logic g, input logic rv, input logic [RW-1:0] rd);
        req = rq; a = aa; rready = rr; mgnt = g; mrvalid = rv; mr = rd;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive(0, '0, 0, 0, 0, '0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic          req;
        logic [AW-1:0] a;
        logic          rready;
        logic          mgnt;
        logic          mrv;
        logic [RW-1:0] mr;
        logic          eg;
        logic          emreq;
        logic          erv;
        logic [RW-1:0] er;
    } vec_t;

    vec_t tbl[14];

    // Reference model state for the random phase
    int            cred;
    int            sub_pend;
    bit            hold;
    logic [RW-1:0] rq[$];

    initial begin
        // req  a      rr mg rv r       eg mr rv r
        tbl[0]  = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,   8'h00};
        tbl[1]  = '{1, 8'h11, 0, 1, 0, 8'h00, 1, 1, 0,   8'h00};
        tbl[2]  = '{1, 8'h22, 0, 1, 0, 8'h00, 1, 1, 0,   8'h00};
        tbl[3]  = '{1, 8'h33, 0, 1, 0, 8'h00, 0, 0, 0,   8'h00};
        tbl[4]  = '{1, 8'h33, 0, 1, 1, 8'h0A, 0, 0, BYP, BYP ? 8'h0A : 8'h00};
        tbl[5]  = '{1, 8'h33, 0, 1, 1, 8'h0B, 0, 0, 1,   8'h0A};
        tbl[6]  = '{1, 8'h33, 1, 1, 0, 8'h00, 0, 0, 1,   8'h0A};
        tbl[7]  = '{1, 8'h33, 1, 1, 0, 8'h00, 1, 1, 1,   8'h0B};
        tbl[8]  = '{0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0,   8'h00};
        tbl[9]  = '{1, 8'h44, 0, 1, 0, 8'h00, 1, 1, 0,   8'h00};
        tbl[10] = '{0, 8'h00, 0, 1, 1, 8'h0C, 0, 0, BYP, BYP ? 8'h0C : 8'h00};
        tbl[11] = '{0, 8'h00, 1, 1, 1, 8'h0D, 0, 0, 1,   8'h0C};
        tbl[12] = '{1, 8'h55, 1, 1, 0, 8'h00, 1, 1, 1,   8'h0D};
        tbl[13] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,   8'h00};

        // Reset state
        rst_ni = 1'b0;
        drive(0, '0, 0, 0, 0, '0);
        #2;
        chk("reset.rvalid", 32'(o_rvalid), 32'd0);
        chk("reset.rdata",  32'(o_r),      32'd0);
        mgnt = 1'b1; req = 1'b1; #1;
        chk("reset.gnt_follows",  32'(o_gnt),  32'd1);
        chk("reset.mreq_follows", 32'(o_mreq), 32'd1);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            drive(tbl[i].req, tbl[i].a, tbl[i].rready, tbl[i].mgnt, tbl[i].mrv, tbl[i].mr);
            #2;
            check_outs($sformatf("vec%0d", i), tbl[i].eg, tbl[i].emreq, tbl[i].erv, tbl[i].er);
        end

        // R latency: response on cycle N with rready high
        do_reset();
        @(negedge clk_i); drive(1, 8'h61, 1, 1, 0, '0); #2;
        check_outs("lat.req", 1, 1, 0, '0);
        @(negedge clk_i); drive(0, '0, 1, 0, 1, 8'h5A); #2;
        check_outs("lat.N", 0, 0, BYP, BYP ? 8'h5A : 8'h00);
        @(negedge clk_i); drive(0, '0, 1, 0, 0, '0); #2;
        check_outs("lat.N1", 0, 0, !BYP, BYP ? 8'h00 : 8'h5A);
        @(negedge clk_i); #2;
        check_outs("lat.N2", 0, 0, 0, '0);

        // Async reset with two buffered responses
        do_reset();
        @(negedge clk_i); drive(1, 8'h71, 0, 1, 0, '0);
        @(negedge clk_i); drive(1, 8'h72, 0, 1, 0, '0);
        @(negedge clk_i); drive(0, '0, 0, 1, 1, 8'hE1);
        @(negedge clk_i); drive(0, '0, 0, 1, 1, 8'hE2);
        @(negedge clk_i); drive(0, '0, 0, 1, 0, '0); #2;
        check_outs("rst.buffered", 0, 0, 1, 8'hE1);
        rst_ni = 1'b0;
        drive(0, '0, 0, 0, 0, '0);
        #1;
        chk("rst.async_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst.async_rdata",  32'(o_r),      32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1, 8'h81, 0, 0, 0, '0); #2;
        check_outs("rst.after0", 0, 1, 0, '0);
        @(negedge clk_i); drive(1, 8'h81, 0, 1, 0, '0); #2;
        check_outs("rst.after1", 1, 1, 0, '0);
        @(negedge clk_i); drive(0, '0, 0, 1, 0, '0); #2;
        check_outs("rst.after2", 1, 0, 0, '0);

        // Random traffic against the queue model
        do_reset();
        cred = 0; sub_pend = 0; hold = 0; rq.delete();
        begin
            int rr_bias = 4;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic          full, eg, emreq, erv, ahs, was_empty, byp_taken;
                logic [RW-1:0] er;
                @(negedge clk_i);
                if (cyc % 64 == 0) rr_bias = int'($urandom_range(0, 8));
                if (!hold) begin
                    req = 1'($urandom_range(0, 1));
                    a   = AW'($urandom());
                end
                rready  = (int'($urandom_range(0, 7)) < rr_bias);
                mgnt    = 1'($urandom_range(0, 1));
                mrvalid = (sub_pend > 0) && ($urandom_range(0, 1) == 1);
                mr      = RW'($urandom());

                full  = (cred == DEPTH);
                eg    = mgnt && !full;
                emreq = req && !full;
                was_empty = (rq.size() == 0);
                if (!was_empty) begin
                    erv = 1'b1; er = rq[0];
                end else if (BYP && mrvalid) begin
                    erv = 1'b1; er = mr;
                end else begin
                    erv = 1'b0; er = '0;
                end
                #2;
                check_outs("rand", eg, emreq, erv, er);

                ahs       = req && eg;
                byp_taken = BYP && was_empty && mrvalid && rready;
                if (!was_empty && rready) void'(rq.pop_front());
                if (mrvalid && !byp_taken) rq.push_back(mr);
                cred     = cred + int'(ahs) - int'(erv && rready);
                sub_pend = sub_pend + int'(ahs) - int'(mrvalid);
                hold     = req && !eg;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
